rename_dispatch_queue: RTL and testbench
========================================

RENAME_DISPATCH_QUEUE -- requirements
Module: rename_dispatch_queue

Interface
REQ-001 Parameter LANES, default 4, number of dispatch lanes per bundle.
REQ-002 Parameter PKT_W, default 128, width in bits of one lane's dispatch packet.
REQ-003 Parameter DEPTH, default 4, bundle entries held; power of two, minimum 2.
REQ-004 clk  input  1  the block's single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush_i  input  1  pipeline flush; discards all held and incoming bundles.
REQ-007 laneActive_i  input  LANES  per-lane power/config enable; inactive lanes are isolated.
REQ-008 bundleValid_i  input  1  rename offers a bundle this cycle.
REQ-009 laneValid_i  input  LANES  per-lane valid within the offered bundle.
REQ-010 pkt_i  input  LANES*PKT_W  lane packets; lane k occupies bits [k*PKT_W +: PKT_W].
REQ-011 bundleReady_o  output  1  queue accepts a bundle this cycle.
REQ-012 stall_i  input  1  dispatch cannot take the head bundle this cycle.
REQ-013 bundleValid_o  output  1  head bundle presented to dispatch.
REQ-014 laneValid_o  output  LANES  per-lane valid of the head bundle.
REQ-015 pkt_o  output  LANES*PKT_W  head bundle packets, same lane packing as pkt_i.
REQ-016 count_o  output  clog2(DEPTH+1)  number of bundles currently held.

Function
REQ-017 Storage shall be a circular buffer of DEPTH entries, each holding LANES lane-valid bits and LANES*PKT_W packet bits, with head/tail pointers wrapping modulo DEPTH.
REQ-018 bundleReady_o shall equal (count_o != DEPTH) & ~flush_i, driven from registered state only (no combinational path from stall_i).
REQ-019 Push: bundleValid_i & bundleReady_o & |(laneValid_i & laneActive_i); entry stores laneValid_i & laneActive_i and pkt_i; tail advances.
REQ-020 A bundle with bundleValid_i=1 whose masked lane-valid is all zero shall be accepted (handshake completes) but not stored; count and tail unchanged.
REQ-021 bundleValid_o shall be (count_o != 0) & ~flush_i; head entry presented combinationally from storage.
REQ-022 Pop: bundleValid_o & ~stall_i; head advances.
REQ-023 Minimum latency: bundle pushed at edge N is presented at bundleValid_o in the cycle after edge N; no same-cycle bypass.
REQ-024 Simultaneous push and pop shall leave count unchanged and advance both pointers; permitted at any occupancy from 1 to DEPTH-1.
REQ-025 When full, push is refused even if a pop occurs the same cycle.
REQ-026 laneValid_o[k] shall equal stored lane-valid[k] & laneActive_i[k] & bundleValid_o.
REQ-027 Isolation: for any lane with laneValid_o[k]=0, pkt_o lane k shall read all zeros.
REQ-028 If masking in REQ-026 clears every lane of a held head entry, bundleValid_o stays 1 with laneValid_o all zero, and the entry pops normally.
REQ-029 flush_i at edge N shall zero count, head and tail; no push or pop takes effect that cycle; bundleValid_o, laneValid_o and bundleReady_o are 0 while flush_i is high.
REQ-030 count_o shall never exceed DEPTH nor underflow below 0 under any input sequence.

Reset
REQ-031 reset at a rising edge shall zero count, head and tail regardless of all other inputs, including mid-push/pop.
REQ-032 During and after reset: count_o=0, bundleValid_o=0, laneValid_o=0, pkt_o=0, bundleReady_o=1 (when flush_i=0).
REQ-033 Storage array contents need not be reset; they are unobservable because of REQ-026/REQ-027.

Verification
REQ-034 Fill: LANES=4, DEPTH=4, stall_i=1, push 5 bundles with laneValid_i=4'b1111 -> first 4 accepted, count_o=4, bundleReady_o=0 on 5th; release stall -> bundles emerge in order, one per cycle.
REQ-035 Streaming: push and pop every cycle from count 1 -> count_o stays 1, data order preserved, with no bubbles across 2*DEPTH pointer wraps.
REQ-036 Lane masking: laneActive_i=4'b0011, push laneValid_i=4'b1111 -> laneValid_o=4'b0011, pkt_o lanes 2,3 zero; push laneValid_i=4'b1100 -> accepted, count_o unchanged.
REQ-037 Flush with concurrent push and pop at count 3 -> next cycle count_o=0, bundleValid_o=0; the bundle offered during flush is absent.
REQ-038 Reset asserted with count 2 and bundleValid_i=1 -> next cycle count_o=0, bundleValid_o=0, pkt_o=0.
REQ-039 Full plus pop: count 4, stall_i=0, bundleValid_i=1 -> pop occurs, push refused, count_o=3.

Source files
------------

// File: rtl/rename_dispatch_queue.sv
// Bundle queue between rename and dispatch: a circular buffer of lane bundles
// with per-lane activity masking and isolation of inactive lanes on the output.
module rename_dispatch_queue #(
  parameter int unsigned LANES = 4,
  parameter int unsigned PKT_W = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic [LANES-1:0]             laneActive_i,
  input  logic                         bundleValid_i,
  input  logic [LANES-1:0]             laneValid_i,
  input  logic [LANES*PKT_W-1:0]       pkt_i,
  output logic                         bundleReady_o,
  input  logic                         stall_i,
  output logic                         bundleValid_o,
  output logic [LANES-1:0]             laneValid_o,
  output logic [LANES*PKT_W-1:0]       pkt_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned BUS_W = LANES * PKT_W;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [LANES-1:0] mem_valid_q [DEPTH];
  logic [BUS_W-1:0] mem_pkt_q   [DEPTH];

  logic [LANES-1:0] in_valid;
  logic             push;
  logic             pop;

  // Handshake outputs depend only on registered state and flush
  always_comb begin
    bundleReady_o = (count_q != CNT_W'(DEPTH)) & ~flush_i;
    bundleValid_o = (count_q != '0) & ~flush_i;
    laneValid_o   = mem_valid_q[head_q] & laneActive_i & {LANES{bundleValid_o}};
    count_o       = count_q;
  end

  // Zero the packet of every lane that is not presented as valid
  always_comb begin
    pkt_o = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      pkt_o[k*PKT_W +: PKT_W] = mem_pkt_q[head_q][k*PKT_W +: PKT_W] & {PKT_W{laneValid_o[k]}};
    end
  end

  always_comb begin
    in_valid = laneValid_i & laneActive_i;
    push     = bundleValid_i & bundleReady_o & (|in_valid);
    pop      = bundleValid_o & ~stall_i;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is left unreset; stale entries are never presented
  always_ff @(posedge clk) begin
    if (push) begin
      mem_valid_q[tail_q] <= in_valid;
      mem_pkt_q[tail_q]   <= pkt_i;
    end
  end

endmodule

// File: tb/tb_rename_dispatch_queue.sv
// Directed self-checking bench for rename_dispatch_queue (LANES=4, PKT_W=128, DEPTH=4).
module tb_rename_dispatch_queue;

  localparam int unsigned LANES = 4;
  localparam int unsigned PKT_W = 128;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BUS_W = LANES * PKT_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush_i;
  logic [LANES-1:0] laneActive_i;
  logic             bundleValid_i;
  logic [LANES-1:0] laneValid_i;
  logic [BUS_W-1:0] pkt_i;
  logic             bundleReady_o;
  logic             stall_i;
  logic             bundleValid_o;
  logic [LANES-1:0] laneValid_o;
  logic [BUS_W-1:0] pkt_o;
  logic [2:0]       count_o;

  int total = 0;
  int bad   = 0;

  rename_dispatch_queue #(.LANES(LANES), .PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .laneActive_i  (laneActive_i),
    .bundleValid_i (bundleValid_i),
    .laneValid_i   (laneValid_i),
    .pkt_i         (pkt_i),
    .bundleReady_o (bundleReady_o),
    .stall_i       (stall_i),
    .bundleValid_o (bundleValid_o),
    .laneValid_o   (laneValid_o),
    .pkt_o         (pkt_o),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] mk(input int id);
    logic [BUS_W-1:0] p;
    p = '0;
    for (int k = 0; k < int'(LANES); k++) p[k*PKT_W +: PKT_W] = (PKT_W'(id) << 8) | PKT_W'(k);
    return p;
  endfunction

  function automatic logic [BUS_W-1:0] msk(input logic [BUS_W-1:0] p, input logic [LANES-1:0] lv);
    logic [BUS_W-1:0] r;
    r = p;
    for (int k = 0; k < int'(LANES); k++) if (!lv[k]) r[k*PKT_W +: PKT_W] = '0;
    return r;
  endfunction

  // Advance one edge and land 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input logic [LANES-1:0] lv);
    bundleValid_i = 1'b1;
    laneValid_i   = lv;
    pkt_i         = mk(id);
    tick();
    bundleValid_i = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; laneActive_i = 4'b1111; bundleValid_i = 1'b0;
    laneValid_i = '0; pkt_i = '0; stall_i = 1'b1;
    tick(); tick();
    #1;
    chk("rst_count", BUS_W'(count_o), 0);
    chk("rst_bv", BUS_W'(bundleValid_o), 0);
    chk("rst_lv", BUS_W'(laneValid_o), 0);
    chk("rst_pkt", pkt_o, 0);
    chk("rst_ready", BUS_W'(bundleReady_o), 1);
    reset = 1'b0;
    tick();

    // Fill past capacity while dispatch stalls
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("fill_ready", BUS_W'(bundleReady_o), (i < 4) ? 1 : 0);
      push(i, 4'b1111);
      chk("fill_count", BUS_W'(count_o), (i < 4) ? i + 1 : 4);
    end
    chk("full_bv", BUS_W'(bundleValid_o), 1);
    chk("full_lv", BUS_W'(laneValid_o), 4'b1111);
    stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_bv", BUS_W'(bundleValid_o), 1);
      chk("drain_pkt", pkt_o, mk(i));
      tick();
    end
    chk("drain_count", BUS_W'(count_o), 0);
    chk("drain_bv_low", BUS_W'(bundleValid_o), 0);

    // Streaming at occupancy 1 across several pointer wraps
    push(100, 4'b1111);
    chk("stream_first_bv", BUS_W'(bundleValid_o), 1);
    for (int i = 0; i < 2 * int'(DEPTH * DEPTH); i++) begin
      bundleValid_i = 1'b1; laneValid_i = 4'b1111; pkt_i = mk(101 + i);
      #1;
      chk("stream_bv", BUS_W'(bundleValid_o), 1);
      chk("stream_pkt", pkt_o, mk(100 + i));
      tick();
      chk("stream_count", BUS_W'(count_o), 1);
    end
    bundleValid_i = 1'b0;
    tick();
    chk("stream_end_count", BUS_W'(count_o), 0);

    // Lane masking and isolation
    stall_i = 1'b1; laneActive_i = 4'b0011;
    push(200, 4'b1111);
    chk("mask_count", BUS_W'(count_o), 1);
    chk("mask_lv", BUS_W'(laneValid_o), 4'b0011);
    chk("mask_pkt", pkt_o, msk(mk(200), 4'b0011));
    bundleValid_i = 1'b1; laneValid_i = 4'b1100; pkt_i = mk(201);
    #1;
    chk("empty_bundle_ready", BUS_W'(bundleReady_o), 1);
    tick();
    bundleValid_i = 1'b0;
    chk("empty_bundle_count", BUS_W'(count_o), 1);
    push(202, 4'b1111);
    chk("mask_count2", BUS_W'(count_o), 2);
    laneActive_i = 4'b0000;
    #1;
    chk("allmask_bv", BUS_W'(bundleValid_o), 1);
    chk("allmask_lv", BUS_W'(laneValid_o), 0);
    chk("allmask_pkt", pkt_o, 0);
    stall_i = 1'b0;
    tick();
    stall_i = 1'b1;
    chk("allmask_pop_count", BUS_W'(count_o), 1);
    laneActive_i = 4'b1111;
    #1;
    chk("stored_mask_lv", BUS_W'(laneValid_o), 4'b0011);
    chk("stored_mask_pkt", pkt_o, msk(mk(202), 4'b0011));
    stall_i = 1'b0;
    tick();
    chk("mask_end_count", BUS_W'(count_o), 0);

    // Flush with concurrent push and pop at count 3
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) push(300 + i, 4'b1111);
    chk("preflush_count", BUS_W'(count_o), 3);
    flush_i = 1'b1; stall_i = 1'b0;
    bundleValid_i = 1'b1; laneValid_i = 4'b1111; pkt_i = mk(303);
    #1;
    chk("flush_bv", BUS_W'(bundleValid_o), 0);
    chk("flush_lv", BUS_W'(laneValid_o), 0);
    chk("flush_ready", BUS_W'(bundleReady_o), 0);
    tick();
    flush_i = 1'b0; bundleValid_i = 1'b0;
    #1;
    chk("postflush_count", BUS_W'(count_o), 0);
    chk("postflush_bv", BUS_W'(bundleValid_o), 0);
    stall_i = 1'b1;
    push(304, 4'b1111);
    chk("postflush_pkt", pkt_o, mk(304));
    chk("postflush_count1", BUS_W'(count_o), 1);

    // Reset mid-traffic
    push(305, 4'b1111);
    chk("prereset_count", BUS_W'(count_o), 2);
    reset = 1'b1; bundleValid_i = 1'b1; stall_i = 1'b0; pkt_i = mk(306);
    tick();
    reset = 1'b0; bundleValid_i = 1'b0; stall_i = 1'b1;
    #1;
    chk("midrst_count", BUS_W'(count_o), 0);
    chk("midrst_bv", BUS_W'(bundleValid_o), 0);
    chk("midrst_pkt", pkt_o, 0);
    chk("midrst_ready", BUS_W'(bundleReady_o), 1);

    // Full plus pop: push refused
    for (int i = 0; i < 4; i++) push(400 + i, 4'b1111);
    chk("full2_count", BUS_W'(count_o), 4);
    stall_i = 1'b0; bundleValid_i = 1'b1; laneValid_i = 4'b1111; pkt_i = mk(404);
    #1;
    chk("full2_ready", BUS_W'(bundleReady_o), 0);
    tick();
    bundleValid_i = 1'b0;
    chk("full2_pop_count", BUS_W'(count_o), 3);
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("full2_order", pkt_o, mk(400 + i));
      tick();
    end
    chk("full2_end_count", BUS_W'(count_o), 0);
    chk("full2_end_bv", BUS_W'(bundleValid_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
